// File: rtl/aes_128_sched.sv
// aes_128_sched: round-robin, credit-gated sharing of one pipelined aes_128 core between two requesters.
// Define AES_SCHED_STATS_EN to add per-requester issue counters and a no-credit stall counter.
module aes_128_sched #(
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_state,
  input  logic [127:0]     req0_key,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_state,
  input  logic [127:0]     req1_key,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [127:0]     core_state,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_data,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_issued0,
  output logic [31:0]      stat_issued1,
  output logic [31:0]      stat_stall
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 129 + TAG_W;
  logic [AW:0] reserved, wr_ptr, rd_ptr;
  logic rr, sel, issue, credit, pop, wr, empty, full;
  logic [LATENCY-1:0] vld;
  logic [TAG_W:0] sh_st [LATENCY];
  logic [EW-1:0] mem [FIFO_DEPTH];
  // reserved counts in-flight plus queued blocks, so a free credit always has a FIFO slot behind it
  always_comb begin
    pop = rsp_valid & rsp_ready;
    credit = (reserved < (AW+1)'(FIFO_DEPTH)) | pop;
    sel = (req0_valid & req1_valid) ? ~rr : req1_valid;
    issue = ~rst & (req0_valid | req1_valid) & credit;
    req0_ready = issue & ~sel;
    req1_ready = issue & sel;
    core_state = issue ? (sel ? req1_state : req0_state) : '0;
    core_key = issue ? (sel ? req1_key : req0_key) : '0;
    wr = vld[LATENCY-1];
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
    rsp_valid = ~rst & ~empty;
    {rsp_src, rsp_tag, rsp_data} = mem[rd_ptr[AW-1:0]];
    busy = ~rst & (reserved != '0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      reserved <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld <= '0;
      rr <= 1'b1;
    end else begin
      reserved <= reserved + (AW+1)'(issue) - (AW+1)'(pop);
      wr_ptr <= wr_ptr + (AW+1)'(wr);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      vld <= {vld[LATENCY-2:0], issue};
      if (issue) rr <= sel;
    end
  // payload of the tracker and FIFO storage need no reset; only valid bits and pointers do
  always_ff @(posedge clk) begin
    sh_st[0] <= {sel, sel ? req1_tag : req0_tag};
    for (int i = 1; i < LATENCY; i++) sh_st[i] <= sh_st[i-1];
    if (wr) mem[wr_ptr[AW-1:0]] <= {sh_st[LATENCY-1], core_out};
  end
`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_issued0 <= '0;
      stat_issued1 <= '0;
      stat_stall <= '0;
    end else begin
      stat_issued0 <= stat_issued0 + 32'(req0_ready);
      stat_issued1 <= stat_issued1 + 32'(req1_ready);
      stat_stall <= stat_stall + 32'((req0_valid | req1_valid) & ~credit);
    end
`endif
`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && wr && full) begin
      $display("E");
      $finish;
    end
`endif
endmodule
